// File: rtl/uart_apb_stream_bridge.sv
// uart_apb_stream_bridge: APB master that polls a UART slave's status register,
// drains received bytes onto a stream output and feeds queued stream bytes
// from a small TX FIFO into the UART data register.
module uart_apb_stream_bridge #(
    parameter int unsigned TX_DEPTH = 8,
    parameter int unsigned POLL_GAP = 2
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    output logic [2:0] err_pulse,
    output logic       bus_err
);

    localparam int unsigned PTR_W = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [4:0] ADDR_TX   = 5'h00;
    localparam logic [4:0] ADDR_RX   = 5'h04;
    localparam logic [4:0] ADDR_STAT = 5'h10;

    // Last value of the gap counter before polling resumes.
    localparam logic [3:0] GAP_LAST = (POLL_GAP == 0) ? 4'd0 : 4'(POLL_GAP - 1);

    typedef enum logic [3:0] {
        IDLE,
        POLL_SETUP,
        POLL_ACCESS,
        DECIDE,
        TX_SETUP,
        TX_ACCESS,
        RX_SETUP,
        RX_ACCESS,
        GAP
    } state_t;

    state_t state;

    logic [7:0]       mem [TX_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;
    logic [1:0]       status_q;   // {RXRDY, TXRDY} from the latest poll
    logic [3:0]       gap_cnt;

    assign push = s_tvalid & s_tready;
    assign pop  = (state == TX_ACCESS) & PREADY;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // FIFO storage; contents are don't-care while the slot is empty.
    always_ff @(posedge PCLK) begin
        if (push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    // FIFO pointers, occupancy and registered ready.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            s_tready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_next;
            s_tready <= (count_next != CNT_W'(TX_DEPTH));
        end
    end

    // Polling FSM with registered APB, stream and pulse outputs.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            err_pulse <= '0;
            bus_err   <= 1'b0;
            status_q  <= '0;
            gap_cnt   <= '0;
        end else begin
            err_pulse <= '0;
            bus_err   <= 1'b0;

            if (m_tvalid && m_tready) begin
                m_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    state   <= POLL_SETUP;
                    PSEL    <= 1'b1;
                    PENABLE <= 1'b0;
                    PWRITE  <= 1'b0;
                    PADDR   <= ADDR_STAT;
                end

                POLL_SETUP: begin
                    state   <= POLL_ACCESS;
                    PENABLE <= 1'b1;
                end

                POLL_ACCESS: begin
                    if (PREADY) begin
                        status_q  <= PRDATA[1:0];
                        err_pulse <= PRDATA[4:2];
                        bus_err   <= PSLVERR;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= DECIDE;
                    end
                end

                DECIDE: begin
                    // Receive has priority, but only into an empty output slot.
                    if (status_q[1] && !m_tvalid) begin
                        state  <= RX_SETUP;
                        PSEL   <= 1'b1;
                        PADDR  <= ADDR_RX;
                        PWRITE <= 1'b0;
                    end else if (status_q[0] && (count != '0)) begin
                        state  <= TX_SETUP;
                        PSEL   <= 1'b1;
                        PADDR  <= ADDR_TX;
                        PWRITE <= 1'b1;
                        PWDATA <= mem[rd_ptr];
                    end else begin
                        state  <= POLL_SETUP;
                        PSEL   <= 1'b1;
                        PADDR  <= ADDR_STAT;
                        PWRITE <= 1'b0;
                    end
                end

                RX_SETUP: begin
                    state   <= RX_ACCESS;
                    PENABLE <= 1'b1;
                end

                RX_ACCESS: begin
                    if (PREADY) begin
                        m_tdata  <= PRDATA;
                        m_tvalid <= 1'b1;
                        bus_err  <= PSLVERR;
                        state    <= POLL_SETUP;
                        PSEL     <= 1'b1;
                        PENABLE  <= 1'b0;
                        PADDR    <= ADDR_STAT;
                        PWRITE   <= 1'b0;
                    end
                end

                TX_SETUP: begin
                    state   <= TX_ACCESS;
                    PENABLE <= 1'b1;
                end

                TX_ACCESS: begin
                    if (PREADY) begin
                        bus_err <= PSLVERR;
                        PENABLE <= 1'b0;
                        PWRITE  <= 1'b0;
                        if (POLL_GAP == 0) begin
                            state <= POLL_SETUP;
                            PSEL  <= 1'b1;
                            PADDR <= ADDR_STAT;
                        end else begin
                            state   <= GAP;
                            PSEL    <= 1'b0;
                            gap_cnt <= '0;
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= POLL_SETUP;
                        PSEL    <= 1'b1;
                        PADDR   <= ADDR_STAT;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    PWRITE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_stream_bridge.sv
// tb_uart_apb_stream_bridge: directed and randomized checks of the UART APB
// stream bridge against an APB slave model and queue-based reference model.
module tb_uart_apb_stream_bridge;

    localparam int unsigned TX_DEPTH = 8;
    localparam int unsigned POLL_GAP = 2;

    logic       PCLK = 1'b0;
    logic       PRESETN = 1'b0;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b0;
    logic [4:0] PADDR;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;
    logic [2:0] err_pulse;
    logic       bus_err;

    uart_apb_stream_bridge #(.TX_DEPTH(TX_DEPTH), .POLL_GAP(POLL_GAP)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .err_pulse(err_pulse), .bus_err(bus_err)
    );

    always #5 PCLK = ~PCLK;

    // ---------------- APB UART slave model ----------------
    logic [7:0] status_val = 8'h00;
    logic [7:0] rx_fixed = 8'h00;
    logic [7:0] rx_rnd = 8'h00;
    bit         rand_rx = 1'b0;
    bit         rand_waits = 1'b0;
    bit         slverr_en = 1'b0;
    int         fixed_wait = 0;
    int         rnd_wait = 0;
    int         wait_cnt = 0;

    assign PREADY  = (wait_cnt >= (rand_waits ? rnd_wait : fixed_wait));
    assign PRDATA  = (PADDR == 5'h10) ? status_val : (rand_rx ? rx_rnd : rx_fixed);
    assign PSLVERR = slverr_en & PWRITE;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (PREADY) begin
                wait_cnt <= 0;
                rnd_wait <= int'($urandom_range(0, 2));
                if (!PWRITE && PADDR == 5'h04) rx_rnd <= 8'($urandom);
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    // ---------------- upstream driver ----------------
    logic [7:0] up_q[$];

    always @(posedge PCLK) begin
        if (s_tvalid && s_tready) void'(up_q.pop_front());
        #1;
        if (up_q.size() != 0) begin
            s_tvalid = 1'b1;
            s_tdata  = up_q[0];
        end else begin
            s_tvalid = 1'b0;
        end
    end

    // ---------------- reference model / observers ----------------
    logic [7:0] tx_exp[$];     // bytes accepted upstream, in order
    logic [7:0] wr_got[$];     // bytes written to the UART TX register
    logic [7:0] rx_exp[$];     // bytes returned by UART RX reads
    logic [7:0] rx_got[$];     // bytes accepted downstream
    logic [4:0] data_log[$];   // addresses of non-status transfers
    int         gap_q[$];
    logic [4:0] next_q[$];
    int occ = 0, rd_cnt = 0, bus_err_cnt = 0, stab_err = 0, bad_xfer = 0;
    int rdy_err = 0, acc_len = 0, last_wr_acc = 0, idle = 0;
    bit in_rst = 1'b1, measuring = 1'b0;
    logic       prev_psel = 1'b0, prev_pen = 1'b0, prev_write = 1'b0;
    logic [4:0] prev_addr = '0;
    logic [7:0] prev_wdata = '0;

    always @(posedge PCLK) begin
        if (!PRESETN) begin
            in_rst = 1'b1; occ = 0; measuring = 1'b0; acc_len = 0;
            prev_psel = 1'b0; prev_pen = 1'b0;
        end else begin
            in_rst = 1'b0;
            if (PSEL && PENABLE) begin
                if (!(prev_psel && PADDR == prev_addr && PWRITE == prev_write &&
                      (!PWRITE || PWDATA == prev_wdata)))
                    stab_err++;
                acc_len++;
            end
            if (prev_psel && !prev_pen && !(PSEL && PENABLE)) stab_err++;
            if (measuring) begin
                if (!PSEL) idle++;
                else begin
                    gap_q.push_back(idle);
                    next_q.push_back(PADDR);
                    measuring = 1'b0;
                end
            end
            if (PSEL && PENABLE && PREADY) begin
                if (PADDR == 5'h00 && PWRITE) begin
                    wr_got.push_back(PWDATA);
                    data_log.push_back(PADDR);
                    occ--;
                    last_wr_acc = acc_len;
                    measuring = 1'b1;
                    idle = 0;
                end else if (PADDR == 5'h04 && !PWRITE) begin
                    rx_exp.push_back(PRDATA);
                    data_log.push_back(PADDR);
                    rd_cnt++;
                end else if (!(PADDR == 5'h10 && !PWRITE)) begin
                    bad_xfer++;
                end
                acc_len = 0;
            end
            if (s_tvalid && s_tready) begin
                tx_exp.push_back(s_tdata);
                occ++;
            end
            if (m_tvalid && m_tready) rx_got.push_back(m_tdata);
            if (bus_err) bus_err_cnt++;
            prev_psel = PSEL; prev_pen = PENABLE; prev_write = PWRITE;
            prev_addr = PADDR; prev_wdata = PWDATA;
        end
    end

    // Ready must reflect the modelled occupancy every cycle out of reset.
    always @(negedge PCLK) begin
        if (!in_rst && (s_tready !== (occ < int'(TX_DEPTH)))) rdy_err++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic clear_queues();
        tx_exp.delete(); wr_got.delete(); rx_exp.delete(); rx_got.delete();
        data_log.delete(); gap_q.delete(); next_q.delete();
    endtask

    logic [7:0] exp_d[$];
    int         base;

    initial begin
        // Reset values.
        PRESETN = 1'b0;
        tick(3);
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_psel", 32'(PSEL), 0);
        chk("rst_penable", 32'(PENABLE), 0);
        chk("rst_pwrite", 32'(PWRITE), 0);
        chk("rst_paddr", 32'(PADDR), 0);
        chk("rst_pwdata", 32'(PWDATA), 0);
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_m_tdata", 32'(m_tdata), 0);
        chk("rst_err_pulse", 32'(err_pulse), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        PRESETN = 1'b1;
        tick(1);
        chk("rel_s_tready", 32'(s_tready), 1);
        chk("first_poll_psel", 32'(PSEL), 1);
        chk("first_poll_paddr", 32'(PADDR), 32'h10);
        chk("first_poll_penable", 32'(PENABLE), 0);

        // Three bytes written in order, each followed by the gap and a poll.
        status_val = 8'h01;
        up_q.push_back(8'h41); up_q.push_back(8'h42); up_q.push_back(8'h43);
        for (int i = 0; i < 300 && wr_got.size() < 3; i++) tick(1);
        tick(12);
        chk("tx3_count", 32'(wr_got.size()), 3);
        if (wr_got.size() >= 3) begin
            chk("tx3_b0", 32'(wr_got[0]), 32'h41);
            chk("tx3_b1", 32'(wr_got[1]), 32'h42);
            chk("tx3_b2", 32'(wr_got[2]), 32'h43);
        end
        chk("tx3_gaps", 32'(gap_q.size()), 3);
        for (int i = 0; i < gap_q.size() && i < 3; i++) begin
            chk("tx3_gap_len", 32'(gap_q[i]), POLL_GAP);
            chk("tx3_next_poll", 32'(next_q[i]), 32'h10);
        end
        clear_queues();

        // Received byte held under back-pressure, no further RX reads.
        m_tready = 1'b0;
        rx_fixed = 8'h5A;
        status_val = 8'h02;
        for (int i = 0; i < 100 && !m_tvalid; i++) tick(1);
        chk("rx_valid", 32'(m_tvalid), 1);
        chk("rx_data", 32'(m_tdata), 32'h5A);
        base = rd_cnt;
        tick(40);
        chk("rx_no_reread", 32'(rd_cnt - base), 0);
        chk("rx_hold_valid", 32'(m_tvalid), 1);
        chk("rx_hold_data", 32'(m_tdata), 32'h5A);
        status_val = 8'h00;
        tick(5);
        m_tready = 1'b1;
        tick(1);
        m_tready = 1'b0;
        chk("rx_drained", 32'(m_tvalid), 0);
        chk("rx_got_count", 32'(rx_got.size()), 1);
        if (rx_got.size() >= 1) chk("rx_got_byte", 32'(rx_got[0]), 32'h5A);
        clear_queues();

        // RX takes priority over a pending TX.
        up_q.push_back(8'h77);
        tick(10);
        data_log.delete();
        rx_fixed = 8'h33;
        status_val = 8'h03;
        for (int i = 0; i < 200 && data_log.size() < 2; i++) tick(1);
        status_val = 8'h00;
        chk("prio_count", 32'(data_log.size()), 2);
        if (data_log.size() >= 2) begin
            chk("prio_first_rx", 32'(data_log[0]), 32'h04);
            chk("prio_then_tx", 32'(data_log[1]), 32'h00);
        end
        if (wr_got.size() >= 1) chk("prio_tx_byte", 32'(wr_got[0]), 32'h77);
        m_tready = 1'b1;
        tick(5);
        m_tready = 1'b0;
        chk("prio_rx_count", 32'(rx_got.size()), 1);
        if (rx_got.size() >= 1) chk("prio_rx_byte", 32'(rx_got[0]), 32'h33);
        clear_queues();

        // Fill past capacity while the UART is not ready, then drain.
        exp_d.delete();
        for (int i = 0; i < int'(TX_DEPTH) + 2; i++) begin
            exp_d.push_back(8'($urandom));
            up_q.push_back(exp_d[i]);
        end
        tick(int'(TX_DEPTH) + 6);
        chk("full_accepted", 32'(tx_exp.size()), TX_DEPTH);
        chk("full_pending", 32'(up_q.size()), 2);
        chk("full_s_tready", 32'(s_tready), 0);
        status_val = 8'h01;
        for (int i = 0; i < 1000 && wr_got.size() < int'(TX_DEPTH) + 2; i++) tick(1);
        chk("full_drain_count", 32'(wr_got.size()), TX_DEPTH + 2);
        for (int i = 0; i < wr_got.size() && i < exp_d.size(); i++)
            chk("full_drain_byte", 32'(wr_got[i]), 32'(exp_d[i]));
        chk("ready_vs_occupancy", 32'(rdy_err), 0);
        clear_queues();

        // Wait states with slave error on a TX write.
        fixed_wait = 3;
        slverr_en = 1'b1;
        base = bus_err_cnt;
        up_q.push_back(8'hC3);
        for (int i = 0; i < 200 && wr_got.size() < 1; i++) tick(1);
        tick(30);
        chk("werr_count", 32'(wr_got.size()), 1);
        if (wr_got.size() >= 1) chk("werr_byte", 32'(wr_got[0]), 32'hC3);
        chk("werr_access_len", 32'(last_wr_acc), 4);
        chk("werr_bus_err_pulses", 32'(bus_err_cnt - base), 1);
        chk("werr_stable", 32'(stab_err), 0);
        slverr_en = 1'b0;
        fixed_wait = 0;
        clear_queues();

        // Error flags from status pulse for one cycle.
        status_val = 8'h1C;
        for (int i = 0; i < 50 && err_pulse == 3'b000; i++) tick(1);
        chk("err_pulse_high", 32'(err_pulse), 32'h7);
        tick(1);
        chk("err_pulse_low", 32'(err_pulse), 0);

        // Reset during an RX access.
        status_val = 8'h02;
        fixed_wait = 5;
        for (int i = 0; i < 100 && !(PSEL && PENABLE && PADDR == 5'h04); i++) tick(1);
        chk("rxa_reached", 32'(PSEL && PENABLE && PADDR == 5'h04), 1);
        PRESETN = 1'b0;
        tick(1);
        chk("rxa_rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rxa_rst_m_tdata", 32'(m_tdata), 0);
        chk("rxa_rst_psel", 32'(PSEL), 0);
        chk("rxa_rst_penable", 32'(PENABLE), 0);
        chk("rxa_no_capture", 32'(rx_exp.size()), 0);
        status_val = 8'h00;
        fixed_wait = 0;
        tick(1);
        PRESETN = 1'b1;
        tick(1);
        chk("rxa_rel_s_tready", 32'(s_tready), 1);
        clear_queues();

        // Randomized traffic against the queue model.
        rand_waits = 1'b1;
        rand_rx = 1'b1;
        for (int i = 0; i < 60; i++) up_q.push_back(8'($urandom));
        for (int c = 0; c < 2000; c++) begin
            m_tready = 1'($urandom_range(0, 1));
            if (c % 16 == 0) status_val = 8'($urandom_range(0, 31));
            tick(1);
        end
        status_val = 8'h01;
        m_tready = 1'b1;
        for (int i = 0; i < 3000 && !(up_q.size() == 0 && occ == 0 && !m_tvalid); i++) tick(1);
        tick(10);
        chk("rnd_tx_count", 32'(wr_got.size()), 32'(tx_exp.size()));
        chk("rnd_tx_total", 32'(tx_exp.size()), 60);
        for (int i = 0; i < wr_got.size() && i < tx_exp.size(); i++)
            chk("rnd_tx_byte", 32'(wr_got[i]), 32'(tx_exp[i]));
        chk("rnd_rx_count", 32'(rx_got.size()), 32'(rx_exp.size()));
        for (int i = 0; i < rx_got.size() && i < rx_exp.size(); i++)
            chk("rnd_rx_byte", 32'(rx_got[i]), 32'(rx_exp[i]));
        chk("rnd_ready_vs_occupancy", 32'(rdy_err), 0);
        chk("rnd_apb_stable", 32'(stab_err), 0);
        chk("rnd_apb_legal", 32'(bad_xfer), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
